// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared types and defaults for the energy meter and its neighbours.
//   bullet_state_t : state of one bullet slot (IDLE/ACTIVE/EXPLODE/DONE)
//   energy_state_t : per-channel energy FSM state (CHARGE/FULL/DRAIN)
//   DRAIN_RATE_DEFAULT / REGEN_PERIOD_DEFAULT : default tuning values
//   bullet_can_hit() : true for bullet states that are allowed to score
// -----------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACTIVE  = 2'b01,
        EXPLODE = 2'b10,
        DONE    = 2'b11
    } bullet_state_t;

    typedef enum logic [1:0] {
        CHARGE = 2'b00,
        FULL   = 2'b01,
        DRAIN  = 2'b10
    } energy_state_t;

    localparam int DRAIN_RATE_DEFAULT   = 4;
    localparam int REGEN_PERIOD_DEFAULT = 12;

    // Only live or exploding bullets deal damage; idle/finished slots are stale.
    function automatic logic bullet_can_hit(bullet_state_t s);
        return (s == ACTIVE) || (s == EXPLODE);
    endfunction

endpackage

// File: rtl/energy_meter_if.sv
// -----------------------------------------------------------------------------
// energy_meter_if
// Per-channel control handshake of the energy meter.
//   clr       : synchronous per-channel energy clear      (master -> slave)
//   spend_req : request/hold the special-move drain       (master -> slave)
//   spend_ack : one-cycle pulse when a drain starts       (slave -> master)
//   is_ready  : channel is full                           (slave -> master)
// -----------------------------------------------------------------------------
interface energy_meter_if #(
    parameter int N_CH = 2
);
    logic [N_CH-1:0] clr;
    logic [N_CH-1:0] spend_req;
    logic [N_CH-1:0] spend_ack;
    logic [N_CH-1:0] is_ready;

    modport master (
        output clr,
        output spend_req,
        input  spend_ack,
        input  is_ready
    );

    modport slave (
        input  clr,
        input  spend_req,
        output spend_ack,
        output is_ready
    );
endinterface

// File: rtl/regen_timer.sv
// -----------------------------------------------------------------------------
// regen_timer
// Frame counter that runs 0..PERIOD-1 while enabled and flags the terminal
// count so the owner can add one unit of passive regeneration.
//   frame_clk : clock (one edge per frame)
//   reset     : asynchronous active-high reset
//   en        : count this frame
//   sclr      : synchronous clear to 0 (wins over en)
//   tick      : high during the frame whose edge wraps the counter
// -----------------------------------------------------------------------------
module regen_timer #(
    parameter int PERIOD = 12
) (
    input  logic frame_clk,
    input  logic reset,
    input  logic en,
    input  logic sclr,
    output logic tick
);
    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] count_q, count_d;

    assign tick = en && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (sclr) begin
            count_d = '0;
        end else if (en) begin
            count_d = tick ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge frame_clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/energy_meter.sv
// -----------------------------------------------------------------------------
// energy_meter
// N_CH independent special-move energy meters plus the energy-bar pixel test.
// Each channel charges from qualifying bullet hits and a slow passive regen,
// latches FULL at full_energy, and drains at DRAIN_RATE while spend_req is
// held after being acknowledged.
//   frame_clk, reset : clock and asynchronous active-high reset
//   hit              : [ch][slot] hit flags
//   bullet_state     : per-slot bullet state
//   damage_unit      : base gain per hit (each hit adds twice this)
//   full_energy      : saturation level
//   ctl              : clr / spend_req in, spend_ack / is_ready out
//   energy           : current energy per channel
//   DrawX, DrawY     : pixel coordinate under test
//   is_energybar     : pixel lies on any bar
//   bar_ch           : lowest-index channel owning the pixel
//   bar_draining     : owning channel is draining
// -----------------------------------------------------------------------------
module energy_meter
    import game_pkg::*;
#(
    parameter int N_CH         = 2,
    parameter int N_BULLETS    = 20,
    parameter int W            = 10,
    parameter int REGEN_PERIOD = REGEN_PERIOD_DEFAULT,
    parameter int DRAIN_RATE   = DRAIN_RATE_DEFAULT,
    parameter int X_MIN        = 10,
    parameter int Y_MIN        = 50,
    parameter int BAR_H        = 20,
    parameter int Y_PITCH      = 30
) (
    input  logic                              frame_clk,
    input  logic                              reset,
    input  logic [N_CH-1:0][N_BULLETS-1:0]    hit,
    input  bullet_state_t [N_BULLETS-1:0]     bullet_state,
    input  logic [W-1:0]                      damage_unit,
    input  logic [W-1:0]                      full_energy,
    energy_meter_if.slave                     ctl,
    output logic [N_CH-1:0][W-1:0]            energy,
    input  logic [W-1:0]                      DrawX,
    input  logic [W-1:0]                      DrawY,
    output logic                              is_energybar,
    output logic [$clog2(N_CH)-1:0]           bar_ch,
    output logic                              bar_draining
);
    localparam int CH_W = $clog2(N_CH);
    // Wide enough for N_BULLETS * 2 * damage_unit plus energy and regen.
    localparam int SW = W + 6;

    energy_state_t [N_CH-1:0] state_all;
    logic [N_CH-1:0]          bar_hit;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        localparam int Y_TOP = Y_MIN + gi * Y_PITCH;

        energy_state_t state_q, state_d;
        logic [W-1:0]  energy_q, energy_d;
        logic          ack_q, ack_d;
        logic          ready_q, ready_d;
        logic [SW-1:0] gain, total;
        logic          regen_tick;
        logic          tmr_clr;

        regen_timer #(
            .PERIOD (REGEN_PERIOD)
        ) u_regen (
            .frame_clk (frame_clk),
            .reset     (reset),
            .en        (state_q == CHARGE),
            .sclr      (tmr_clr),
            .tick      (regen_tick)
        );

        always_comb begin
            gain = '0;
            for (int i = 0; i < N_BULLETS; i++) begin
                if (hit[gi][i] && bullet_can_hit(bullet_state[i])) begin
                    gain = gain + {5'b0, damage_unit, 1'b0};
                end
            end
            total = {6'b0, energy_q} + gain + SW'(regen_tick);
        end

        always_comb begin
            state_d  = state_q;
            energy_d = energy_q;
            ack_d    = 1'b0;
            if (ctl.clr[gi]) begin
                state_d  = CHARGE;
                energy_d = '0;
            end else begin
                case (state_q)
                    CHARGE: begin
                        // >= also catches full_energy dropping below energy.
                        if (total >= {6'b0, full_energy}) begin
                            energy_d = full_energy;
                            state_d  = FULL;
                        end else begin
                            energy_d = total[W-1:0];
                        end
                    end
                    FULL: begin
                        if (energy_q > full_energy) begin
                            energy_d = full_energy;
                        end
                        if (ctl.spend_req[gi]) begin
                            state_d = DRAIN;
                            ack_d   = 1'b1;
                        end
                    end
                    DRAIN: begin
                        // Releasing the button keeps whatever is left.
                        if (!ctl.spend_req[gi]) begin
                            state_d = CHARGE;
                        end else if (energy_q <= W'(DRAIN_RATE)) begin
                            energy_d = '0;
                            state_d  = CHARGE;
                        end else begin
                            energy_d = energy_q - W'(DRAIN_RATE);
                        end
                    end
                    default: begin
                        state_d  = CHARGE;
                        energy_d = '0;
                    end
                endcase
            end
            ready_d = (state_d == FULL);
            // Timer only runs while charging and restarts from 0 on re-entry.
            tmr_clr = ctl.clr[gi] || (state_d != CHARGE);
        end

        always_ff @(posedge frame_clk or posedge reset) begin
            if (reset) begin
                state_q  <= CHARGE;
                energy_q <= '0;
                ack_q    <= 1'b0;
                ready_q  <= 1'b0;
            end else begin
                state_q  <= state_d;
                energy_q <= energy_d;
                ack_q    <= ack_d;
                ready_q  <= ready_d;
            end
        end

        assign energy[gi]        = energy_q;
        assign state_all[gi]     = state_q;
        assign ctl.spend_ack[gi] = ack_q;
        assign ctl.is_ready[gi]  = ready_q;

        // Bar spans X_MIN .. X_MIN+energy-1; compared in 32 bits to avoid wrap.
        assign bar_hit[gi] = (energy_q != '0)
                          && (32'(DrawX) >= X_MIN)
                          && (32'(DrawX) <  X_MIN + 32'(energy_q))
                          && (32'(DrawY) >= Y_TOP)
                          && (32'(DrawY) <  Y_TOP + BAR_H);
    end

    // Scan high to low so the lowest overlapping channel wins.
    always_comb begin
        is_energybar = 1'b0;
        bar_ch       = '0;
        bar_draining = 1'b0;
        for (int c = N_CH - 1; c >= 0; c--) begin
            if (bar_hit[c]) begin
                is_energybar = 1'b1;
                bar_ch       = CH_W'(c);
                bar_draining = (state_all[c] == DRAIN);
            end
        end
    end
endmodule

// File: doc/energy_meter.md
ENERGY_METER -- requirements
Module: energy_meter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  N_CH, 2, independent energy channels (one per player).
  N_BULLETS, 20, bullet slots scanned for hits.
  W, 10, energy/coordinate width.
  REGEN_PERIOD, 12, frames per passive +1 energy.
  DRAIN_RATE, 4, energy removed per frame while draining.
  X_MIN, 10; Y_MIN, 50; BAR_H, 20; Y_PITCH, 30: bar geometry.
REQ-002 Ports (name  direction  width  meaning):
  frame_clk  in  1  sole clock, one edge per video frame.
  reset  in  1  asynchronous, active-high.
  hit  in  N_CH x N_BULLETS  per-channel hit flags.
  bullet_state  in  N_BULLETS x 2  bullet state (bullet_state_t).
  damage_unit  in  W  base gain per hit.
  full_energy  in  W  saturation level.
  clr  in  N_CH  synchronous per-channel energy clear.
  spend_req  in  N_CH  request/hold special-move drain.
  spend_ack  out  N_CH  one-cycle pulse on drain start.
  is_ready  out  N_CH  channel full.
  energy  out  N_CH x W  current energy.
  DrawX, DrawY  in  W  pixel coordinate.
  is_energybar  out  1  pixel lies on any bar.
  bar_ch  out  $clog2(N_CH)  lowest-index channel owning the pixel.
  bar_draining  out  1  owning channel is in DRAIN.
REQ-003 Single clock frame_clk; reset asynchronous, active-high; all state registers on frame_clk.

Function
REQ-004 Per-channel FSM states CHARGE, FULL, DRAIN; channels fully independent.
REQ-005 Qualifying hit: hit[c][i]=1 and bullet_state[i] in {ACTIVE(01), EXPLODE(10)}; each adds 2*damage_unit.
REQ-006 Gain sum computed in W+6 bits; next energy saturates at full_energy, never wraps.
REQ-007 Regen timer per channel counts 0..REGEN_PERIOD-1 in CHARGE; at terminal count adds +1 and wraps to 0.
REQ-008 CHARGE: energy <= min(energy+hits+regen, full_energy); if that sum >= full_energy, energy <= full_energy and state -> FULL.
REQ-009 FULL: hits/regen ignored, timer held at 0; spend_req=1 -> DRAIN, spend_ack pulses exactly that cycle.
REQ-010 DRAIN: hits/regen ignored; energy decrements DRAIN_RATE per frame; if energy <= DRAIN_RATE, energy <= 0 and -> CHARGE.
REQ-011 spend_req deasserted in DRAIN -> CHARGE next edge, residual energy kept, timer restarts at 0.
REQ-012 spend_req in CHARGE ignored; no ack.
REQ-013 clr[c] overrides all events: energy 0, timer 0, state CHARGE, no ack.
REQ-014 full_energy lowered below energy in CHARGE -> clamp, FULL next edge; in FULL -> energy clamped to new value, stays FULL; full_energy=0 -> FULL one edge after reset release.
REQ-015 is_ready[c] = (state==FULL), registered; spend_ack registered.
REQ-016 Drawing combinational: channel c hit when energy>0, X_MIN <= DrawX <= X_MIN+energy-1, Y_MIN+c*Y_PITCH <= DrawY < Y_MIN+c*Y_PITCH+BAR_H; overlap resolved to lowest c.

Reset
REQ-017 On reset: all energy 0, timers 0, states CHARGE, spend_ack 0, is_ready 0; bar outputs follow energy=0 (no bar pixels).
REQ-018 reset mid-DRAIN aborts drain with no further ack.

Structure
REQ-019 game_pkg holds bullet_state_t (IDLE/ACTIVE/EXPLODE/DONE), energy_state_t, DRAIN_RATE/REGEN_PERIOD defaults.
REQ-020 One sub-module regen_timer (per channel, generate loop): enable, sync clear, terminal pulse.

Verification
REQ-021 full=100, damage=5, channel 0 hits slots 3,7 ACTIVE one frame -> energy[0] +20, energy[1] unchanged.
REQ-022 No hits, 24 frames from reset -> energy 2 both channels; DONE-state hits add nothing.
REQ-023 energy 95, full 100, 2 qualifying hits -> energy 100, is_ready=1 next edge, no overshoot.
REQ-024 FULL 100, spend_req held -> one ack, energy 96,92,...,4, then 0, CHARGE, is_ready=0.
REQ-025 DRAIN at 60, drop spend_req -> CHARGE at 60; simultaneous clr+spend_req in FULL -> 0, no ack.
REQ-026 energy[0]=30: DrawY=55, DrawX=39 -> is_energybar=1, bar_ch=0; DrawX=40 -> 0; reset asserted asynchronously mid-frame -> outputs zero before next edge.
